// File: rtl/regbank_alu_arbiter_pkg.sv
// Shared types for the register-bank/ALU arbiter.
// Holds the sequencer states, the default widths and the request bundle.
package regbank_alu_pkg;

  localparam int ADDR_W = 4;
  localparam int FUNC_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_SETTLE,
    S_OUT_LO,
    S_OUT_HI
  } state_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dst;
  } req_t;

endpackage

// File: rtl/regbank_alu_arbiter_if.sv
// Request-side valid/ready handshake for one requester.
// The master drives the operation; the slave returns the grant.
interface regbank_alu_arbiter_if #(
  parameter int ADDR_W = regbank_alu_pkg::ADDR_W,
  parameter int FUNC_W = regbank_alu_pkg::FUNC_W
);

  logic              valid;
  logic              ready;
  logic [FUNC_W-1:0] func;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] dst;

  modport master (
    output valid, func, src1, src2, dst,
    input  ready
  );

  modport slave (
    input  valid, func, src1, src2, dst,
    output ready
  );

endinterface

// File: rtl/regbank_alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant.
// The pointer remembers the last winner and moves only on an accept.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  logic r_ptr;

  always_comb begin
    o_gnt_valid = |i_valid;
    o_gnt_id    = 1'b0;
    unique case (1'b1)
      (i_valid == 2'b11): o_gnt_id = ~r_ptr;
      (i_valid == 2'b10): o_gnt_id = 1'b1;
      default:            o_gnt_id = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b1;
    end else if (i_accept) begin
      r_ptr <= o_gnt_id;
    end
  end

endmodule

// File: rtl/regbank_alu_arbiter.sv
// Shares one register-bank/ALU datapath between two requesters.
// Sequences read, write and settle, then returns the result in two beats.
module regbank_alu_arbiter #(
  parameter int ADDR_W = regbank_alu_pkg::ADDR_W,
  parameter int FUNC_W = regbank_alu_pkg::FUNC_W,
  parameter int DATA_W = regbank_alu_pkg::DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  regbank_alu_arbiter_if.slave  i_req0,
  regbank_alu_arbiter_if.slave  i_req1,
  output logic                  o_rb_read,
  output logic                  o_rb_write,
  output logic [ADDR_W-1:0]     o_rb_src1,
  output logic [ADDR_W-1:0]     o_rb_src2,
  output logic [ADDR_W-1:0]     o_rb_dst,
  output logic [FUNC_W-1:0]     o_alu_func,
  input  logic [DATA_W-1:0]     i_rb_rdata,
  output logic [DATA_W/2-1:0]   o_out,
  output logic                  o_out_valid,
  output logic                  o_out_last,
  output logic                  o_out_id
);

  import regbank_alu_pkg::*;

  localparam int HALF = DATA_W / 2;

  state_t            r_state;
  state_t            w_next;
  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_accept;
  logic              w_idle;
  logic [FUNC_W-1:0] w_func;
  logic [ADDR_W-1:0] w_src1;
  logic [ADDR_W-1:0] w_src2;
  logic [ADDR_W-1:0] w_dst;

  logic              r_rb_read;
  logic              r_rb_write;
  logic [FUNC_W-1:0] r_func;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src2;
  logic [ADDR_W-1:0] r_dst;
  logic              r_id;
  logic [HALF-1:0]   r_out;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_out_id;

  rr_arbiter2 u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     ({i_req1.valid, i_req0.valid}),
    .i_accept    (w_accept),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = w_idle && w_gnt_valid;
  assign i_req0.ready = w_accept && !w_gnt_id;
  assign i_req1.ready = w_accept && w_gnt_id;

  always_comb begin
    w_func = i_req0.func;
    w_src1 = i_req0.src1;
    w_src2 = i_req0.src2;
    w_dst  = i_req0.dst;
    if (w_gnt_id) begin
      w_func = i_req1.func;
      w_src1 = i_req1.src1;
      w_src2 = i_req1.src2;
      w_dst  = i_req1.dst;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = S_READ;
      S_READ:   w_next = S_WRITE;
      S_WRITE:  w_next = S_SETTLE;
      S_SETTLE: w_next = S_OUT_LO;
      S_OUT_LO: w_next = S_OUT_HI;
      S_OUT_HI: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rb_read   <= 1'b0;
      r_rb_write  <= 1'b0;
      r_func      <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_dst       <= '0;
      r_id        <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_id    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rb_read   <= (w_next == S_READ);
      r_rb_write  <= (w_next == S_WRITE);
      r_out_valid <= (w_next == S_OUT_LO) || (w_next == S_OUT_HI);
      r_out_last  <= (w_next == S_OUT_HI);
      r_out_id    <= ((w_next == S_OUT_LO) || (w_next == S_OUT_HI)) && r_id;
      if (w_next == S_OUT_LO) begin
        r_out <= i_rb_rdata[HALF-1:0];
      end else if (w_next == S_OUT_HI) begin
        r_out <= i_rb_rdata[DATA_W-1:HALF];
      end else begin
        r_out <= '0;
      end
      if (w_accept) begin
        r_func <= w_func;
        r_src1 <= w_src1;
        r_src2 <= w_src2;
        r_dst  <= w_dst;
        r_id   <= w_gnt_id;
      end
    end
  end

  // A reset seen during WRITE must suppress the write landing on that edge
  assign o_rb_write  = r_rb_write && i_rst_n;
  assign o_rb_read   = r_rb_read;
  assign o_rb_src1   = r_src1;
  assign o_rb_src2   = r_src2;
  assign o_rb_dst    = r_dst;
  assign o_alu_func  = r_func;
  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_id    = r_out_id;

endmodule
